kernel_window: RTL

- Consumer end of the line-buffer chain.
- Accepts one vertical pixel column per handshake: KERNEL_WIDTH stacked pixels, built from the custom FIFO outputs plus the live pixel.
- Shifts each column into a KERNEL_WIDTH x KERNEL_WIDTH register window.
- Emits only windows that lie fully inside an image row; windows that straddle a row wrap are dropped.
- Feeds the gradient/HOG stages downstream through a valid/ready interface.

---
 rtl/hog_pkg.sv | 19 +
 rtl/window_shift_reg.sv | 48 ++++
 rtl/kernel_window.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/hog_pkg.sv
// Shared definitions for the line-buffer / kernel-window / HOG pipeline:
// window FSM encodings, default frame geometry and the pixel-slice helper.
package hog_pkg;

    typedef enum logic [1:0] {
        S_FILL = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } win_state_t;

    localparam int DEF_IMG_WIDTH  = 854;
    localparam int DEF_IMG_HEIGHT = 480;

    // Bit offset of window pixel (r, c) inside a flattened K x K window.
    function automatic int pix_base(input int r, input int c, input int k, input int dw);
        return (r * k + c) * dw;
    endfunction

endpackage

// File: rtl/window_shift_reg.sv
// K x K pixel register array. Each shift moves every column one step left
// and loads the incoming column into the rightmost position.
module window_shift_reg
    import hog_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int KERNEL_WIDTH = 3
) (
    input  logic                                             clk,
    input  logic                                             rst,
    input  logic                                             shift_en,
    input  logic [KERNEL_WIDTH*DATA_WIDTH-1:0]               col_in,
    output logic [KERNEL_WIDTH*KERNEL_WIDTH*DATA_WIDTH-1:0]  win_out
);

    localparam int K   = KERNEL_WIDTH;
    localparam int DW  = DATA_WIDTH;
    localparam int TOT = K * K * DW;

    logic [TOT-1:0] win_q;
    logic [TOT-1:0] win_d;

    always_comb begin
        win_d = win_q;
        if (shift_en) begin
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K; c++) begin
                    if (c == K - 1) begin
                        win_d[pix_base(r, c, K, DW) +: DW] = col_in[r*DW +: DW];
                    end else begin
                        win_d[pix_base(r, c, K, DW) +: DW] = win_q[pix_base(r, c + 1, K, DW) +: DW];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_q <= '0;
        end else begin
            win_q <= win_d;
        end
    end

    assign win_out = win_q;

endmodule

// File: rtl/kernel_window.sv
// Consumer end of the line-buffer chain: shifts pixel columns into a K x K
// window and emits only windows lying fully inside one image row.
module kernel_window
    import hog_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int KERNEL_WIDTH = 3,
    parameter int IMG_WIDTH    = DEF_IMG_WIDTH,
    parameter int IMG_HEIGHT   = DEF_IMG_HEIGHT
) (
    input  logic                                             clk,
    input  logic                                             rst,
    input  logic [KERNEL_WIDTH*DATA_WIDTH-1:0]               col_data,
    input  logic                                             col_valid,
    output logic                                             col_ready,
    output logic [KERNEL_WIDTH*KERNEL_WIDTH*DATA_WIDTH-1:0]  win_data,
    output logic                                             win_valid,
    input  logic                                             win_ready,
    output logic [$clog2(IMG_WIDTH)-1:0]                     win_col,
    output logic [$clog2(IMG_HEIGHT)-1:0]                    win_row,
    output logic                                             win_last
);

    localparam int K  = KERNEL_WIDTH;
    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);

    localparam logic [CW-1:0] COL_LAST     = CW'(IMG_WIDTH - 1);
    localparam logic [CW-1:0] COL_FILL_END = CW'(K - 2);
    localparam logic [RW-1:0] ROW_LAST     = RW'(IMG_HEIGHT - K);

    win_state_t    state_q, state_d;
    logic [CW-1:0] col_cnt_q, col_cnt_d;
    logic [RW-1:0] row_cnt_q, row_cnt_d;
    logic          win_valid_q, win_valid_d;
    logic          win_last_q, win_last_d;
    logic [CW-1:0] win_col_q, win_col_d;
    logic [RW-1:0] win_row_q, win_row_d;

    logic accept;
    logic out_hs;

    // A new column may only enter when the output slot is free or being drained.
    assign col_ready = (state_q != S_DONE) && (!win_valid_q || win_ready);
    assign accept    = col_valid && col_ready;
    assign out_hs    = win_valid_q && win_ready;

    always_comb begin
        state_d     = state_q;
        col_cnt_d   = col_cnt_q;
        row_cnt_d   = row_cnt_q;
        win_valid_d = win_valid_q;
        win_last_d  = win_last_q;
        win_col_d   = win_col_q;
        win_row_d   = win_row_q;

        if (out_hs) begin
            win_valid_d = 1'b0;
            win_last_d  = 1'b0;
        end

        if (accept) begin
            if (col_cnt_q == COL_LAST) begin
                col_cnt_d = '0;
                row_cnt_d = row_cnt_q + 1'b1;
            end else begin
                col_cnt_d = col_cnt_q + 1'b1;
            end

            case (state_q)
                S_FILL: begin
                    if (col_cnt_q == COL_FILL_END) begin
                        state_d = S_RUN;
                    end
                end
                S_RUN: begin
                    win_valid_d = 1'b1;
                    win_col_d   = col_cnt_q;
                    win_row_d   = row_cnt_q;
                    win_last_d  = 1'b0;
                    // End of row: refill so no window spans the row wrap.
                    if (col_cnt_q == COL_LAST) begin
                        if (row_cnt_q == ROW_LAST) begin
                            win_last_d = 1'b1;
                            row_cnt_d  = '0;
                            state_d    = S_DONE;
                        end else begin
                            state_d = S_FILL;
                        end
                    end
                end
                default: begin
                end
            endcase
        end

        if ((state_q == S_DONE) && out_hs) begin
            state_d   = S_FILL;
            col_cnt_d = '0;
            row_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_FILL;
            col_cnt_q   <= '0;
            row_cnt_q   <= '0;
            win_valid_q <= 1'b0;
            win_last_q  <= 1'b0;
            win_col_q   <= '0;
            win_row_q   <= '0;
        end else begin
            state_q     <= state_d;
            col_cnt_q   <= col_cnt_d;
            row_cnt_q   <= row_cnt_d;
            win_valid_q <= win_valid_d;
            win_last_q  <= win_last_d;
            win_col_q   <= win_col_d;
            win_row_q   <= win_row_d;
        end
    end

    window_shift_reg #(
        .DATA_WIDTH   (DATA_WIDTH),
        .KERNEL_WIDTH (KERNEL_WIDTH)
    ) u_shift (
        .clk      (clk),
        .rst      (rst),
        .shift_en (accept),
        .col_in   (col_data),
        .win_out  (win_data)
    );

    assign win_valid = win_valid_q;
    assign win_last  = win_last_q;
    assign win_col   = win_col_q;
    assign win_row   = win_row_q;

endmodule
